// File: rtl/mdio_poll_ctrl.sv
// Multi-PHY MDIO poller: round-robins NUM_PHY PHYs through the mdio_dri op
// interface, publishing link/speed/error vectors and servicing soft resets.
module mdio_poll_ctrl #(
  parameter int          NUM_PHY       = 4,
  parameter logic [4:0]  PHY_ADDR_BASE = 5'h04,
  parameter logic [23:0] POLL_INTERVAL = 24'd1000000,
  parameter logic [15:0] OP_TIMEOUT    = 16'd4096,
  parameter logic [15:0] RST_WORD      = 16'h9140
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PHY-1:0]     soft_rst_trig,
  input  logic                   op_done,
  input  logic [15:0]            op_rd_data,
  input  logic                   op_rd_ack,
  output logic                   op_exec,
  output logic                   op_rh_wl,
  output logic [4:0]             op_phy_addr,
  output logic [4:0]             op_addr,
  output logic [15:0]            op_wr_data,
  output logic [NUM_PHY-1:0]     link,
  output logic [2*NUM_PHY-1:0]   speed,
  output logic [NUM_PHY-1:0]     phy_err,
  output logic                   round_done
);

  typedef enum logic [2:0] {
    IDLE, RST_ISSUE, RST_WAIT, BMSR_ISSUE, BMSR_WAIT, PHYSR_ISSUE, PHYSR_WAIT, NEXT
  } state_t;

  state_t             state, state_n;
  logic [2:0]         idx, cur, rst_idx;
  logic               in_round;
  logic [NUM_PHY-1:0] rst_pend;
  logic [23:0]        ival_cnt;
  logic [15:0]        tmo_cnt;
  logic               rst_any, waiting, tmo, fail, ok;
  logic               unused_bits;

  assign unused_bits = ^{op_rd_data[13:12], op_rd_data[9:3], op_rd_data[1:0]};

  always_comb begin
    rst_any = |rst_pend;
    rst_idx = '0;
    // Walk downward so the lowest pending index wins.
    for (int i = NUM_PHY - 1; i >= 0; i--)
      if (rst_pend[i]) rst_idx = 3'(i);
    waiting = (state == RST_WAIT) || (state == BMSR_WAIT) || (state == PHYSR_WAIT);
    tmo     = waiting && !op_done && (tmo_cnt == OP_TIMEOUT - 16'd1);
    fail    = waiting && ((op_done && op_rd_ack) || tmo);
    ok      = waiting && op_done && !op_rd_ack;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (rst_any)                              state_n = RST_ISSUE;
        else if (in_round || ival_cnt <= 24'd1)   state_n = BMSR_ISSUE;
      end
      RST_ISSUE:   state_n = RST_WAIT;
      BMSR_ISSUE:  state_n = BMSR_WAIT;
      PHYSR_ISSUE: state_n = PHYSR_WAIT;
      RST_WAIT:    if (ok || fail) state_n = IDLE;
      BMSR_WAIT: begin
        if (fail)    state_n = NEXT;
        else if (ok) state_n = op_rd_data[2] ? PHYSR_ISSUE : NEXT;
      end
      PHYSR_WAIT:  if (ok || fail) state_n = NEXT;
      NEXT:        state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      cur         <= '0;
      in_round    <= 1'b0;
      rst_pend    <= '0;
      ival_cnt    <= POLL_INTERVAL;
      tmo_cnt     <= '0;
      op_exec     <= 1'b0;
      op_rh_wl    <= 1'b0;
      op_phy_addr <= '0;
      op_addr     <= '0;
      op_wr_data  <= '0;
      link        <= '0;
      speed       <= '0;
      phy_err     <= '0;
      round_done  <= 1'b0;
    end else begin
      state      <= state_n;
      op_exec    <= 1'b0;
      round_done <= 1'b0;
      rst_pend   <= rst_pend | soft_rst_trig;
      tmo_cnt    <= waiting ? tmo_cnt + 16'd1 : 16'd0;

      if (state == IDLE && !rst_any && !in_round && ival_cnt > 24'd1)
        ival_cnt <= ival_cnt - 24'd1;

      // Op fields are loaded alongside op_exec and then held for the driver.
      if (state == IDLE && state_n == RST_ISSUE) begin
        cur         <= rst_idx;
        op_exec     <= 1'b1;
        op_rh_wl    <= 1'b0;
        op_phy_addr <= PHY_ADDR_BASE + {2'b00, rst_idx};
        op_addr     <= 5'd0;
        op_wr_data  <= RST_WORD;
      end
      if (state == IDLE && state_n == BMSR_ISSUE) begin
        cur         <= idx;
        in_round    <= 1'b1;
        op_exec     <= 1'b1;
        op_rh_wl    <= 1'b1;
        op_phy_addr <= PHY_ADDR_BASE + {2'b00, idx};
        op_addr     <= 5'd1;
        op_wr_data  <= '0;
      end
      if (state == BMSR_WAIT && state_n == PHYSR_ISSUE) begin
        op_exec <= 1'b1;
        op_addr <= 5'h11;
      end

      for (int i = 0; i < NUM_PHY; i++) begin
        if (cur == 3'(i)) begin
          if (ok && (state == RST_WAIT || (state == BMSR_WAIT && !op_rd_data[2]))) begin
            link[i]         <= 1'b0;
            speed[2*i +: 2] <= 2'b00;
          end
          // Unresolved or reserved (11) speed reports as 10M/down.
          if (ok && state == PHYSR_WAIT) begin
            link[i]         <= op_rd_data[11] & op_rd_data[10];
            speed[2*i +: 2] <= (op_rd_data[11] && op_rd_data[15:14] != 2'b11) ?
                               op_rd_data[15:14] : 2'b00;
          end
          if (fail)    phy_err[i] <= 1'b1;
          else if (ok) phy_err[i] <= 1'b0;
          if (state == RST_WAIT && (ok || fail)) rst_pend[i] <= soft_rst_trig[i];
        end
      end

      if (state == NEXT) begin
        if (idx == 3'(NUM_PHY - 1)) begin
          round_done <= 1'b1;
          idx        <= '0;
          in_round   <= 1'b0;
          ival_cnt   <= POLL_INTERVAL;
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_poll_ctrl.sv
// Directed bench for mdio_poll_ctrl: two modelled PHYs behind a 3-cycle
// driver model, table of poll results plus soft-reset/error/timeout/reset cases.
module tb_mdio_poll_ctrl;
  localparam int NP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NP-1:0]   soft_rst_trig;
  logic            op_done, op_rd_ack;
  logic [15:0]     op_rd_data;
  logic            op_exec, op_rh_wl;
  logic [4:0]      op_phy_addr, op_addr;
  logic [15:0]     op_wr_data;
  logic [NP-1:0]   link, phy_err;
  logic [2*NP-1:0] speed;
  logic            round_done;

  mdio_poll_ctrl #(
    .NUM_PHY(NP), .PHY_ADDR_BASE(5'h04), .POLL_INTERVAL(24'd10),
    .OP_TIMEOUT(16'd20), .RST_WORD(16'h9140)
  ) dut (
    .clk(clk), .rst(rst), .soft_rst_trig(soft_rst_trig),
    .op_done(op_done), .op_rd_data(op_rd_data), .op_rd_ack(op_rd_ack),
    .op_exec(op_exec), .op_rh_wl(op_rh_wl), .op_phy_addr(op_phy_addr),
    .op_addr(op_addr), .op_wr_data(op_wr_data), .link(link), .speed(speed),
    .phy_err(phy_err), .round_done(round_done)
  );

  typedef struct packed {
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic        rw;
    logic [15:0] wd;
  } op_t;

  typedef struct {
    logic [15:0] b0, p0, b1, p1;
    logic [1:0]  link;
    logic [3:0]  speed;
  } vec_t;

  int total = 0, bad = 0;
  int exec_run = 0, exec_wide = 0, exec_cnt = 0;
  logic [15:0] bmsr [NP];
  logic [15:0] physr [NP];
  logic        noack [NP];
  logic        silent [NP];
  op_t         oplog [$];

  function automatic op_t mk(input logic [4:0] pa, input logic [4:0] ra,
                             input logic rw, input logic [15:0] wd);
    op_t e;
    e = {pa, ra, rw, wd};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_log(input string nm, input op_t exp[$]);
    chk({nm, "_len"}, 32'(oplog.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < oplog.size(); k++)
      chk($sformatf("%s_op%0d", nm, k), 32'(oplog[k]), 32'(exp[k]));
  endtask

  task automatic wait_round(input string nm);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (round_done) seen = 1'b1;
    end
    chk({nm, "_round"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_exec(input string nm, input logic [4:0] pa, input logic [4:0] ra);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 500) begin
      @(negedge clk);
      n++;
      if (op_exec && op_phy_addr == pa && op_addr == ra) seen = 1'b1;
    end
    chk({nm, "_exec"}, 32'(seen), 32'd1);
  endtask

  // Driver/PHY model: op_done three cycles after op_exec unless the PHY is silent.
  initial begin
    int   dly;
    int   p;
    logic pend;
    logic [4:0] ra;
    op_t  e;
    op_done = 1'b0; op_rd_ack = 1'b0; op_rd_data = '0;
    dly = 0; p = 0; pend = 1'b0; ra = '0;
    forever begin
      @(negedge clk);
      op_done = 1'b0; op_rd_ack = 1'b0; op_rd_data = '0;
      if (op_exec) begin
        exec_cnt++;
        exec_run++;
        if (exec_run > 1) exec_wide++;
        e = mk(op_phy_addr, op_addr, op_rh_wl, op_rh_wl ? 16'h0 : op_wr_data);
        oplog.push_back(e);
        p    = (op_phy_addr == 5'h05) ? 1 : 0;
        ra   = op_addr;
        pend = 1'b1;
        dly  = 3;
      end else begin
        exec_run = 0;
        if (pend) begin
          dly--;
          if (dly == 0) begin
            pend = 1'b0;
            if (!silent[p]) begin
              op_done    = 1'b1;
              op_rd_ack  = noack[p];
              op_rd_data = (ra == 5'd1) ? bmsr[p] : (ra == 5'h11) ? physr[p] : 16'h0;
            end
          end
        end
      end
    end
  end

  initial begin
    vec_t vt[6];
    op_t  q[$];
    int   n;
    logic flag;

    vt[0] = '{16'h0004, 16'hAC00, 16'h0000, 16'h0000, 2'b01, 4'b0010};
    vt[1] = '{16'h0004, 16'hEC00, 16'h0004, 16'h6C00, 2'b11, 4'b0100};
    vt[2] = '{16'h0004, 16'h8400, 16'h0004, 16'h8C00, 2'b10, 4'b1000};
    vt[3] = '{16'h0000, 16'hAC00, 16'h0004, 16'h2C00, 2'b10, 4'b0000};
    vt[4] = '{16'h0004, 16'hE400, 16'h0004, 16'h6C00, 2'b10, 4'b0100};
    vt[5] = '{16'h0004, 16'h0C00, 16'h0004, 16'hAC00, 2'b11, 4'b1000};

    rst = 1'b1;
    soft_rst_trig = '0;
    for (int i = 0; i < NP; i++) begin
      bmsr[i] = '0; physr[i] = '0; noack[i] = 1'b0; silent[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_outputs", {25'd0, op_exec, link, speed, round_done},
        32'd0);
    chk("rst_phy_err", 32'(phy_err), 32'd0);
    oplog.delete();
    rst = 1'b0;

    // Table of poll outcomes, one round each.
    for (int v = 0; v < 6; v++) begin
      bmsr[0] = vt[v].b0; physr[0] = vt[v].p0;
      bmsr[1] = vt[v].b1; physr[1] = vt[v].p1;
      wait_round($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_link", v), 32'(link), 32'(vt[v].link));
      chk($sformatf("vec%0d_speed", v), 32'(speed), 32'(vt[v].speed));
      chk($sformatf("vec%0d_err", v), 32'(phy_err), 32'd0);
      if (v == 0) begin
        q = '{mk(5'h04, 5'd1, 1'b1, 16'h0), mk(5'h04, 5'h11, 1'b1, 16'h0),
              mk(5'h05, 5'd1, 1'b1, 16'h0)};
        chk_log("vec0", q);
        @(negedge clk);
        chk("round_done_width", 32'(round_done), 32'd0);
      end
    end

    // No-ack from PHY0: sticky error, link/speed retained, cleared by a good poll.
    noack[0] = 1'b1;
    wait_round("noack");
    chk("noack_err", 32'(phy_err), 32'b01);
    chk("noack_link", 32'(link), 32'b11);
    chk("noack_speed", 32'(speed), 32'b1000);
    noack[0] = 1'b0;
    wait_round("recover");
    chk("recover_err", 32'(phy_err), 32'd0);

    // Silent PHY0: BMSR wait times out after 20 cycles, then PHY1 is polled.
    silent[0] = 1'b1;
    wait_exec("tmo", 5'h04, 5'd1);
    n = 0;
    while (!phy_err[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd21);
    wait_exec("tmo_next", 5'h05, 5'd1);
    silent[0] = 1'b0;
    wait_round("tmo");
    chk("tmo_err_sticky", 32'(phy_err), 32'b01);

    // Soft reset of PHY1 requested twice mid-round: one write, then PHY1 polled.
    oplog.delete();
    wait_exec("srst", 5'h04, 5'd1);
    @(negedge clk) soft_rst_trig = 2'b10;
    @(negedge clk) soft_rst_trig = 2'b00;
    @(negedge clk) soft_rst_trig = 2'b10;
    @(negedge clk) soft_rst_trig = 2'b00;
    flag = 1'b0;
    n = 0;
    while (!round_done && n < 500) begin
      @(negedge clk);
      n++;
      if (!link[1]) flag = 1'b1;
    end
    chk("srst_round", 32'(round_done), 32'd1);
    chk("srst_link1_dropped", 32'(flag), 32'd1);
    q = '{mk(5'h04, 5'd1, 1'b1, 16'h0), mk(5'h04, 5'h11, 1'b1, 16'h0),
          mk(5'h05, 5'd0, 1'b0, 16'h9140), mk(5'h05, 5'd1, 1'b1, 16'h0),
          mk(5'h05, 5'h11, 1'b1, 16'h0)};
    chk_log("srst", q);
    chk("srst_link", 32'(link), 32'b11);
    chk("srst_err", 32'(phy_err), 32'd0);
    oplog.delete();
    wait_round("srst_after");
    q = '{mk(5'h04, 5'd1, 1'b1, 16'h0), mk(5'h04, 5'h11, 1'b1, 16'h0),
          mk(5'h05, 5'd1, 1'b1, 16'h0), mk(5'h05, 5'h11, 1'b1, 16'h0)};
    chk_log("srst_after", q);

    // rst during PHYSR_WAIT with a late op_done from the driver.
    wait_exec("hrst", 5'h04, 5'h11);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("hrst_outputs", {25'd0, op_exec, link, speed, round_done}, 32'd0);
    chk("hrst_err", 32'(phy_err), 32'd0);
    rst = 1'b0;
    flag = 1'b0;
    n = 0;
    while (!op_exec && n < 100) begin
      @(negedge clk);
      n++;
      if (link != '0 || speed != '0 || phy_err != '0) flag = 1'b1;
    end
    chk("hrst_stray_ignored", 32'(flag), 32'd0);
    chk("hrst_first_op_delay", 32'(n), 32'd10);
    chk("hrst_first_op", {21'd0, op_rh_wl, op_phy_addr, op_addr}, {21'd0, 1'b1, 5'h04, 5'd1});

    chk("exec_one_cycle", 32'(exec_wide), 32'd0);
    chk("exec_seen", 32'(exec_cnt > 20), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
